// File: rtl/or1k_store_queue.sv
// Store queue: a small first-word-fall-through FIFO of pending stores.
// Each entry holds the store's PC, address, data, byte lanes and a
// store-conditional flag.
// Entries live in a register array. The wrap-around pointers are
// DEPTH_WIDTH+1 bits wide, and their MSB tells full apart from empty.
// Optional store-to-load forwarding is compiled in only when the macro
// OR1K_STORE_QUEUE_FORWARD_EN is defined. Without the macro, the lookup
// outputs are tied to zero.
//
// Handshake: a push is taken on write_i && (!full_o || read_i). A pop is
// taken on read_i && !empty_o. The head is valid whenever valid_o is high.
// flush_i and rst both discard every entry at the next rising edge, and
// rst takes priority over flush_i.
module or1k_store_queue #(
  parameter int DEPTH_WIDTH          = 3,
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int AFULL_LEVEL          = (2**DEPTH_WIDTH) - 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [OPTION_OPERAND_WIDTH-1:0]   pc_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]   adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]   dat_i,
  input  logic [OPTION_OPERAND_WIDTH/8-1:0] bsel_i,
  input  logic                              atomic_i,
  input  logic                              write_i,
  output logic [OPTION_OPERAND_WIDTH-1:0]   pc_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]   adr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]   dat_o,
  output logic [OPTION_OPERAND_WIDTH/8-1:0] bsel_o,
  output logic                              atomic_o,
  output logic                              valid_o,
  input  logic                              read_i,
  input  logic                              flush_i,
  output logic                              full_o,
  output logic                              empty_o,
  output logic                              almost_full_o,
  output logic [DEPTH_WIDTH:0]              count_o,
  input  logic [OPTION_OPERAND_WIDTH-1:0]   lookup_adr_i,
  output logic [OPTION_OPERAND_WIDTH-1:0]   lookup_dat_o,
  output logic [OPTION_OPERAND_WIDTH/8-1:0] lookup_bsel_o,
  output logic                              lookup_hit_o
);

  localparam int W     = OPTION_OPERAND_WIDTH;
  localparam int BW    = OPTION_OPERAND_WIDTH / 8;
  localparam int DEPTH = 2**DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0] DEPTH_CNT = (DEPTH_WIDTH+1)'(DEPTH);
  localparam logic [DEPTH_WIDTH:0] AFULL_CNT = (DEPTH_WIDTH+1)'(AFULL_LEVEL);
  localparam logic [DEPTH_WIDTH:0] PTR_ONE   = (DEPTH_WIDTH+1)'(1);

  logic [W-1:0]   pc_mem     [DEPTH];
  logic [W-1:0]   adr_mem    [DEPTH];
  logic [W-1:0]   dat_mem    [DEPTH];
  logic [BW-1:0]  bsel_mem   [DEPTH];
  logic           atomic_mem [DEPTH];

  logic [DEPTH_WIDTH:0]   wr_ptr;
  logic [DEPTH_WIDTH:0]   rd_ptr;
  logic [DEPTH_WIDTH-1:0] wr_idx;
  logic [DEPTH_WIDTH-1:0] rd_idx;
  logic                   push_ok;
  logic                   pop_ok;

  assign wr_idx  = wr_ptr[DEPTH_WIDTH-1:0];
  assign rd_idx  = rd_ptr[DEPTH_WIDTH-1:0];

  // Occupancy follows from the pointer distance. The extra MSB keeps a
  // full queue (distance DEPTH) distinct from an empty one (distance 0).
  assign count_o       = wr_ptr - rd_ptr;
  assign full_o        = (count_o == DEPTH_CNT);
  assign empty_o       = (count_o == '0);
  assign almost_full_o = (count_o >= AFULL_CNT);
  assign valid_o       = !empty_o;

  // A pop frees a slot in the same cycle, so a full queue still accepts a
  // push when read_i is high. A read on an empty queue is ignored.
  assign push_ok = write_i && (!full_o || read_i);
  assign pop_ok  = read_i && !empty_o;

  // Head entry falls through combinationally. The value is don't-care
  // when the queue is empty.
  assign pc_o     = pc_mem[rd_idx];
  assign adr_o    = adr_mem[rd_idx];
  assign dat_o    = dat_mem[rd_idx];
  assign bsel_o   = bsel_mem[rd_idx];
  assign atomic_o = atomic_mem[rd_idx];

  // Pointer update: rst beats flush, and flush beats push/pop.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Entry storage. No reset is needed, because reads are gated by the
  // pointers.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      pc_mem[wr_idx]     <= pc_i;
      adr_mem[wr_idx]    <= adr_i;
      dat_mem[wr_idx]    <= dat_i;
      bsel_mem[wr_idx]   <= bsel_i;
      atomic_mem[wr_idx] <= atomic_i;
    end
  end

`ifdef OR1K_STORE_QUEUE_FORWARD_EN
  logic [W-1:0]           fwd_dat;
  logic [BW-1:0]          fwd_bsel;
  logic [DEPTH_WIDTH:0]   age_ptr;
  logic [DEPTH_WIDTH-1:0] age_idx;
  logic                   unused_lookup_lsb;

  // Byte offset within a word does not take part in the match.
  assign unused_lookup_lsb = ^lookup_adr_i[1:0];

  // Walk the entries from oldest to youngest. A later match overwrites an
  // earlier one, so each lane ends up holding the youngest covering
  // store. The lookup sees pre-edge state, so an entry being popped this
  // cycle still matches.
  always_comb begin
    fwd_dat  = '0;
    fwd_bsel = '0;
    age_ptr  = rd_ptr;
    age_idx  = rd_idx;
    for (int k = 0; k < DEPTH; k++) begin
      age_ptr = rd_ptr + (DEPTH_WIDTH+1)'(k);
      age_idx = age_ptr[DEPTH_WIDTH-1:0];
      if (((DEPTH_WIDTH+1)'(k) < count_o) &&
          (adr_mem[age_idx][W-1:2] == lookup_adr_i[W-1:2])) begin
        for (int b = 0; b < BW; b++) begin
          if (bsel_mem[age_idx][b]) begin
            fwd_bsel[b]       = 1'b1;
            fwd_dat[8*b +: 8] = dat_mem[age_idx][8*b +: 8];
          end
        end
      end
    end
  end

  assign lookup_dat_o  = fwd_dat;
  assign lookup_bsel_o = fwd_bsel;
  assign lookup_hit_o  = |fwd_bsel;
`else
  logic unused_lookup;

  assign unused_lookup = ^lookup_adr_i;
  assign lookup_dat_o  = '0;
  assign lookup_bsel_o = '0;
  assign lookup_hit_o  = 1'b0;
`endif

endmodule

// File: doc/or1k_store_queue.md
OR1K_STORE_QUEUE -- requirements
Module: or1k_store_queue

Interface
REQ-001 SHALL have parameter DEPTH_WIDTH, default 3: log2 of entry count; DEPTH = 2**DEPTH_WIDTH, legal range 1..6.
REQ-002 SHALL have parameter OPTION_OPERAND_WIDTH, default 32: address and data width; multiple of 8.
REQ-003 SHALL have parameter AFULL_LEVEL, default DEPTH-1: occupancy at or above which almost_full_o asserts.
REQ-004 SHALL have port: clk  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports: pc_i, adr_i, dat_i  in  OPTION_OPERAND_WIDTH each  store PC, address and data.
REQ-007 SHALL have ports: bsel_i  in  OPTION_OPERAND_WIDTH/8  byte lanes; atomic_i  in  1  store-conditional flag.
REQ-008 SHALL have port: write_i  in  1  push request.
REQ-009 SHALL have ports: pc_o, adr_o, dat_o, bsel_o, atomic_o  out  widths as the inputs  head entry.
REQ-010 SHALL have ports: valid_o  out  1  head valid; read_i  in  1  pop request.
REQ-011 SHALL have port: flush_i  in  1  discard all entries.
REQ-012 SHALL have ports: full_o, empty_o, almost_full_o  out  1 each; count_o  out  DEPTH_WIDTH+1  occupancy.
REQ-013 SHALL have ports: lookup_adr_i  in  OPTION_OPERAND_WIDTH; lookup_dat_o  out  OPTION_OPERAND_WIDTH; lookup_bsel_o  out  OPTION_OPERAND_WIDTH/8; lookup_hit_o  out  1.

Function
REQ-014 SHALL store entries in a register array, not RAM, with wrap-around read and write pointers DEPTH_WIDTH+1 bits wide.
REQ-015 SHALL present the head entry combinationally, first-word-fall-through; valid_o = !empty_o; head outputs are don't-care when empty.
REQ-016 SHALL accept a push on write_i && (!full_o || read_i); push latency 1 cycle (entry visible at head the next cycle if the queue was empty).
REQ-017 SHALL ignore write_i when full_o && !read_i: entry dropped, pointers and count unchanged.
REQ-018 SHALL ignore read_i when empty_o, including when write_i is asserted in the same cycle.
REQ-019 SHALL on simultaneous accepted push and pop keep count_o unchanged and advance both pointers.
REQ-020 SHALL define full_o as count_o == DEPTH, empty_o as count_o == 0, and almost_full_o as count_o >= AFULL_LEVEL; all combinational from registered state.
REQ-021 SHALL on flush_i set both pointers and count to 0 at the next edge; flush overrides write_i and read_i in the same cycle.
REQ-022 SHALL wrap pointer index bits modulo DEPTH; the pointer MSB distinguishes full from empty.

Reset
REQ-023 SHALL on rst, sampled at the clock edge, clear pointers and count; rst overrides flush_i, write_i and read_i.
REQ-024 SHALL after reset drive empty_o=1, valid_o=0, full_o=0, almost_full_o=0 (AFULL_LEVEL>0), count_o=0, lookup_hit_o=0, lookup_bsel_o=0, lookup_dat_o=0.
REQ-025 SHALL require no reset of array contents; outputs derived from the array are gated by valid entries.

Configuration
REQ-026 SHALL compile store-to-load forwarding only when macro OR1K_STORE_QUEUE_FORWARD_EN is defined.
REQ-027 SHALL with the macro defined, for each byte lane, return the byte from the youngest valid entry whose adr[W-1:2] equals lookup_adr_i[W-1:2] with that bsel bit set; lookup_bsel_o = covered lanes; lookup_hit_o = |lookup_bsel_o; uncovered lanes of lookup_dat_o = 0; combinational, and reflects pre-edge state, so an entry popped in the current cycle still matches.
REQ-028 SHALL without the macro tie lookup_hit_o, lookup_bsel_o and lookup_dat_o to 0 and instantiate no comparator logic.

Verification
REQ-029 SHALL cover: reset, then push 8 entries with DEPTH_WIDTH=3 -> full_o=1 and count_o=8 after the 8th; a 9th push without read_i is dropped; the head is still the 1st entry.
REQ-030 SHALL cover: full queue with write_i and read_i in the same cycle -> count_o stays 8; the new entry emerges as the 8th pop.
REQ-031 SHALL cover: 20 push/pop cycles through wrap-around -> FIFO order preserved; empty_o=1 at the end.
REQ-032 SHALL cover: with forwarding enabled, push adr 0x100 dat 0x11223344 bsel 0xF, then adr 0x100 dat 0xAABBCCDD bsel 0x3; lookup 0x102 -> hit=1, bsel=0xF, dat=0x1122CCDD.
REQ-033 SHALL cover: 5 entries, flush_i asserted with write_i=1 -> next cycle count_o=0, empty_o=1, lookup_hit_o=0.
REQ-034 SHALL cover: rst asserted mid-stream with write_i and read_i high -> next cycle all outputs at the REQ-024 values.
